m_cp0: RTL
==========

# m_cp0

Coprocessor-0 block in the memory (M) stage of the five-stage MIPS pipeline. It holds SR, Cause, EPC and PRId and services mfc0/mtc0/eret. It combines six hardware interrupt lines with the exception code carried down the pipeline, and asserts the single `req` flush that resets the M/W pipeline register and redirects fetch to 0x0000_4180. Its read data feeds the W-stage register's `cp0_in`.

## Interface
Parameters:
- PRID_VALUE, 32'h2021_0707, constant returned for PRId (register 15)

Ports:
- clk  input  1  pipeline clock; all state updates on posedge
- reset  input  1  synchronous, active-high; clears SR, Cause, EPC
- we  input  1  mtc0 in M stage
- addr  input  5  CP0 register number for both read and write
- din  input  32  mtc0 write data (forwarded rt value)
- pc_in  input  32  PC of the M-stage instruction
- bd_in  input  1  M-stage instruction is in a branch delay slot
- exc_code_in  input  5  pipelined ExcCode; 0 = no exception
- eret  input  1  eret in M stage
- hw_int  input  6  external interrupt lines HW[7:2]
- req  output  1  take exception/interrupt this cycle (flush + redirect)
- dout  output  32  mfc0 read data
- epc_out  output  32  EPC value for eret redirect

## Operation
Register fields (all unlisted bits read as 0 and ignore writes):
- SR(12): IM[15:10], EXL[1], IE[0]
- Cause(13): BD[31], IP[15:10] (read-only), ExcCode[6:2] (read-only)
- EPC(14): full 32 bits, read/write
- PRId(15): PRID_VALUE, read-only

Request logic (combinational from registered SR and current inputs):
- int_req = (|(hw_int & IM)) & IE & ~EXL
- exc_req = (exc_code_in != 0) & ~EXL
- req = int_req | exc_req; an interrupt takes priority over an exception in the same cycle.

On posedge when req=1:
- EXL<=1.
- ExcCode <= int_req ? 0 : exc_code_in.
- BD <= bd_in.
- EPC <= bd_in ? pc_in-4 : pc_in. Low two bits are cleared: EPC <= {x[31:2],2'b00}.
- The mtc0 write is suppressed.

On posedge when req=0:
- If we, write SR or EPC per the masks above. Writes to Cause, PRId or other addresses are ignored.
- If eret, EXL<=0. This is applied after any SR write in the same cycle, so EXL ends at 0.

Every posedge, regardless of req: IP <= hw_int.

Read path:
- dout = register at addr, reflecting pre-edge state. Unmapped addresses read 0.
- epc_out = (we & addr==14 & ~req) ? din : EPC. This bypass lets an mtc0 EPC immediately followed by eret redirect correctly.

## Timing
- Reset values: SR=0, Cause=0, EPC=0, req=0, dout=0 for addr≠15, epc_out=0.
- Reset takes priority over req, we and eret at the same edge.
- req is zero-latency: it is asserted in the same cycle as the offending M-stage instruction or an enabled interrupt line. State is committed at that cycle's edge, so EXL=1 is visible one cycle later.
- While EXL=1, req stays 0 for any exc_code_in or hw_int. Nested requests are lost, not queued.
- A pending interrupt (hw_int held) re-asserts req on the first cycle after eret clears EXL.
- Branch-delay wrap: pc_in=0 with bd_in=1 gives EPC=32'hFFFF_FFFC (mod-2^32, no special case).
- IP tracks hw_int with exactly one cycle of lag. It never affects req, which uses live hw_int.

## Test plan
- Reset, then read addr 12/13/14/15 → dout 0, 0, 0, PRID_VALUE. req=0 with hw_int=6'h3F.
- mtc0 SR=32'h0000_FC01, then hw_int=6'b000100 → req=1 same cycle. Next cycle: SR=32'h0000_FC03, Cause ExcCode=0, EPC=pc_in.
- Set IE=1 and IM fully enabled. Drive exc_code_in=5'd12 (Ov), bd_in=1, pc_in=32'h0000_3010 → req=1. Then EPC=32'h0000_300C, Cause=32'h8000_0030.
- With EXL=1, drive exc_code_in=5'd4 and hw_int=6'h01 → req stays 0 and EPC is unchanged. Assert eret → EXL=0 next cycle. req=1 the following cycle while hw_int is held.
- mtc0 EPC=32'h0000_3400 with eret the next cycle → epc_out=32'h0000_3400. Then mtc0 EPC with req=1 in the same cycle → EPC takes pc_in, not din.
- Assert reset in the same cycle as req=1 and we=1 → after the edge, SR, Cause and EPC are all 0.

Source files
------------

// File: rtl/m_cp0.sv
// Coprocessor-0 for the M stage: SR, Cause, EPC, PRId, mfc0/mtc0/eret handling
// and the single exception/interrupt request that flushes M/W and redirects fetch.
module m_cp0 #(
  parameter logic [31:0] PRID_VALUE = 32'h2021_0707
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] din,
  input  logic [31:0] pc_in,
  input  logic        bd_in,
  input  logic [4:0]  exc_code_in,
  input  logic        eret,
  input  logic [5:0]  hw_int,
  output logic        req,
  output logic [31:0] dout,
  output logic [31:0] epc_out
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  logic [31:0] epc;

  logic        int_req;
  logic        exc_req;
  logic [31:0] epc_base;
  logic [31:0] epc_next;
  logic [31:0] sr_val;
  logic [31:0] cause_val;

  // Request decode uses registered SR with live interrupt lines and ExcCode.
  always_comb begin
    int_req  = (|(hw_int & im)) & ie & ~exl;
    exc_req  = (exc_code_in != 5'd0) & ~exl;
    req      = int_req | exc_req;
    epc_base = bd_in ? (pc_in - 32'd4) : pc_in;
    epc_next = {epc_base[31:2], 2'b00};
  end

  // CP0 state update; exception entry wins over mtc0, eret lands after any SR write.
  always_ff @(posedge clk) begin
    if (reset) begin
      im       <= 6'd0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ip       <= 6'd0;
      exc_code <= 5'd0;
      epc      <= 32'd0;
    end else begin
      ip <= hw_int;
      if (req) begin
        exl      <= 1'b1;
        exc_code <= int_req ? 5'd0 : exc_code_in;
        bd       <= bd_in;
        epc      <= epc_next;
      end else begin
        if (we) begin
          case (addr)
            ADDR_SR: begin
              im  <= din[15:10];
              exl <= din[1];
              ie  <= din[0];
            end
            ADDR_EPC: epc <= din;
            default: ;
          endcase
        end
        if (eret) begin
          exl <= 1'b0;
        end
      end
    end
  end

  // mfc0 read mux plus the EPC bypass that lets mtc0 EPC feed a following eret.
  always_comb begin
    sr_val    = {16'd0, im, 8'd0, exl, ie};
    cause_val = {bd, 15'd0, ip, 3'd0, exc_code, 2'b00};
    dout      = 32'd0;
    case (addr)
      ADDR_SR:    dout = sr_val;
      ADDR_CAUSE: dout = cause_val;
      ADDR_EPC:   dout = epc;
      ADDR_PRID:  dout = PRID_VALUE;
      default:    dout = 32'd0;
    endcase
    if (we && (addr == ADDR_EPC) && !req) begin
      epc_out = din;
    end else begin
      epc_out = epc;
    end
  end

endmodule
